// File: rtl/pc_gen_pkg.sv
// Shared types for the program-counter generator: FSM states and redirect sources.
// Redirect source values double as priority ranks (higher value wins).
package pc_gen_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef enum logic [2:0] {
        SRC_NONE = 3'd0,
        SRC_BR   = 3'd1,
        SRC_RET  = 3'd2,
        SRC_JMP  = 3'd3,
        SRC_EXC  = 3'd4
    } src_t;

    // True when source a strictly outranks source b.
    function automatic logic outranks(input src_t a, input src_t b);
        return 3'(a) > 3'(b);
    endfunction

endpackage

// File: rtl/pc_gen_ras.sv
// Circular return-address stack; a push on full overwrites the oldest entry.
// Simultaneous push and pop on a non-empty stack replaces the top entry.
module pc_gen_ras #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            push,
    input  logic            pop,
    input  logic [XLEN-1:0] push_data,
    output logic [XLEN-1:0] top_c,
    output logic            empty_c
);

    localparam int unsigned PW = $clog2(RAS_DEPTH);
    localparam int unsigned CW = $clog2(RAS_DEPTH + 1);

    logic [XLEN-1:0] mem [RAS_DEPTH];
    logic [PW-1:0]   wr_ptr_q;
    logic [CW-1:0]   cnt_q;
    logic [PW-1:0]   top_idx;
    logic            full;
    logic            do_replace;
    logic            do_push;
    logic            do_pop;

    assign top_idx    = wr_ptr_q - PW'(1);
    assign top_c      = mem[top_idx];
    assign empty_c    = (cnt_q == '0);
    assign full       = (cnt_q == CW'(RAS_DEPTH));
    assign do_replace = push && pop && !empty_c;
    assign do_push    = push && !do_replace;
    assign do_pop     = pop && !push && !empty_c;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (do_push) begin
            wr_ptr_q <= wr_ptr_q + PW'(1);
            if (!full) begin
                cnt_q <= cnt_q + CW'(1);
            end
        end else if (do_pop) begin
            wr_ptr_q <= top_idx;
            cnt_q    <= cnt_q - CW'(1);
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk_i) begin
        if (do_replace) begin
            mem[top_idx] <= push_data;
        end else if (do_push) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator with prioritised redirects and stall-time pending capture.
// Optional return-address stack enabled by defining PC_GEN_RAS_EN.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int unsigned     XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_VEC   = '0,
    parameter logic [XLEN-1:0] EXC_VEC     = XLEN'(32'h80),
    parameter int unsigned     INSTR_BYTES = 4,
    parameter int unsigned     RAS_DEPTH   = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic            stall_i,
    input  logic            exc_i,
    input  logic            jmp_i,
    input  logic [XLEN-1:0] jmp_target_i,
    input  logic            br_taken_i,
    input  logic [XLEN-1:0] br_target_i,
    input  logic            call_i,
    input  logic            ret_i,
    output logic [XLEN-1:0] pc_o,
    output logic            pc_valid_o,
    output logic            redir_o,
    output logic            misalign_o,
    output logic            ras_uflow_o
);

    localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(INSTR_BYTES) - XLEN'(1));

    state_t          state_q, state_d;
    src_t            pend_src_q, pend_src_d;
    logic [XLEN-1:0] pend_tgt_q, pend_tgt_d;
    logic [XLEN-1:0] pc_d;
    logic            valid_d, redir_d, misalign_d;
    src_t            new_src, sel_src;
    logic [XLEN-1:0] new_tgt, sel_tgt;

`ifdef PC_GEN_RAS_EN
    logic            ras_push, ras_pop, uflow_d;
    logic [XLEN-1:0] ras_top_c;
    logic            ras_empty_c;

    pc_gen_ras #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pc_o + XLEN'(INSTR_BYTES)),
        .top_c     (ras_top_c),
        .empty_c   (ras_empty_c)
    );
`else
    logic unused_ras_in;
    assign unused_ras_in = call_i ^ ret_i;
    assign ras_uflow_o   = 1'b0;
`endif

    // Next-state, next-PC and pending-redirect selection.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_o;
        valid_d    = pc_valid_o;
        redir_d    = 1'b0;
        misalign_d = 1'b0;
        pend_src_d = pend_src_q;
        pend_tgt_d = pend_tgt_q;
        new_src    = SRC_NONE;
        new_tgt    = '0;
        sel_src    = SRC_NONE;
        sel_tgt    = '0;
`ifdef PC_GEN_RAS_EN
        ras_push   = 1'b0;
        ras_pop    = 1'b0;
        uflow_d    = 1'b0;
`endif

        if (br_taken_i) begin
            new_src = SRC_BR;
            new_tgt = br_target_i;
        end
`ifdef PC_GEN_RAS_EN
        // The stack is only consulted on live cycles; a stalled return is not captured.
        if (ret_i && (state_q == RUN) && start_i && !stall_i && !ras_empty_c) begin
            new_src = SRC_RET;
            new_tgt = ras_top_c;
        end
`endif
        if (jmp_i) begin
            new_src = SRC_JMP;
            new_tgt = jmp_target_i;
        end
        if (exc_i) begin
            new_src = SRC_EXC;
            new_tgt = EXC_VEC;
        end

        case (state_q)
            IDLE: begin
                pc_d       = RESET_VEC;
                valid_d    = 1'b0;
                pend_src_d = SRC_NONE;
                pend_tgt_d = '0;
                if (start_i) begin
                    state_d = RUN;
                    valid_d = 1'b1;
                end
            end
            RUN: begin
                if (stall_i) begin
                    if (new_src != SRC_NONE && !outranks(pend_src_q, new_src)) begin
                        pend_src_d = new_src;
                        pend_tgt_d = new_tgt;
                    end
                end else if (!start_i) begin
                    state_d    = IDLE;
                    pc_d       = RESET_VEC;
                    valid_d    = 1'b0;
                    pend_src_d = SRC_NONE;
                    pend_tgt_d = '0;
                end else begin
                    sel_src = new_src;
                    sel_tgt = new_tgt;
                    if (pend_src_q != SRC_NONE && !outranks(new_src, pend_src_q)) begin
                        sel_src = pend_src_q;
                        sel_tgt = pend_tgt_q;
                    end
                    if (sel_src != SRC_NONE) begin
                        pc_d       = sel_tgt & ALIGN_MASK;
                        redir_d    = 1'b1;
                        misalign_d = |(sel_tgt & ~ALIGN_MASK);
                    end else begin
                        pc_d = pc_o + XLEN'(INSTR_BYTES);
                    end
                    pend_src_d = SRC_NONE;
                    pend_tgt_d = '0;
`ifdef PC_GEN_RAS_EN
                    ras_push = call_i;
                    ras_pop  = ret_i && !ras_empty_c;
                    uflow_d  = ret_i && ras_empty_c;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q    <= IDLE;
            pc_o       <= RESET_VEC;
            pc_valid_o <= 1'b0;
            redir_o    <= 1'b0;
            misalign_o <= 1'b0;
            pend_src_q <= SRC_NONE;
            pend_tgt_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_o       <= pc_d;
            pc_valid_o <= valid_d;
            redir_o    <= redir_d;
            misalign_o <= misalign_d;
            pend_src_q <= pend_src_d;
            pend_tgt_q <= pend_tgt_d;
        end
    end

`ifdef PC_GEN_RAS_EN
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            ras_uflow_o <= 1'b0;
        end else begin
            ras_uflow_o <= uflow_d;
        end
    end
`endif

endmodule
